bmpbound: RTL and testbench
===========================

# bmpbound

Downstream analysis stage of the compare accelerator bitmap path. It consumes the row and column slices that the bitmap register streams out of a 24x64 bitmap, using the register's request/ready handshake. It computes the bitmap's bounding box: topmost and bottommost occupied rows, and the first and last occupied columns. It also counts occupied columns and reports the result with a one-cycle `done` pulse to the compare controller.

## Interface
- `clk` in 1: single clock, all logic on rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `alustart` in 1: pulse from bitmap register; a new bitmap was loaded and its slice counters were re-initialised.
- `columnout` in 64: current column slice. Bit 63 = row 0.
- `toprowout` in 24: current top-scan row slice.
- `botrowout` in 24: current bottom-scan row slice.
- `colready`, `rowtopready`, `rowbotready` in 1: one-cycle pulse; the matching slice input is valid this cycle.
- `nextcol`, `nextrowtop`, `nextrowbot` out 1: registered one-cycle request pulses.
- `lastrowtop`, `lastrowbot` out 1: registered; high blocks the bitmap register from advancing that row counter.
- `busy` out 1: scan in progress.
- `done` out 1: one-cycle result-valid pulse.
- `empty` out 1: bitmap had no set bit; valid with `done`.
- `toprow`, `botrow` out 6: row indices of the top and bottom bounds.
- `colhi`, `collo` out 5: highest and lowest occupied column index.
- `colcnt` out 5: number of nonzero columns, 0..24.
- `err` out 1: handshake timeout; only present with `BMPBOUND_TIMEOUT_EN`.

## Operation
- **Reset values:** all outputs 0, except `lastrowtop` = `lastrowbot` = 1. State is IDLE.
- **States and transitions:**
  - IDLE → TOPREQ on `alustart`.
  - Each scan phase is a REQ/WAIT pair:
    - REQ drives the request pulse for one cycle.
    - WAIT samples the slice on the ready pulse.
  - TOP phase:
    - Rows 63 down to 0. `lastrowtop` is low only during TOP.
    - The first nonzero `toprowout` sets `toprow` to the index and moves to BOT.
    - 64 zero rows set `empty` = 1 and go straight to DONE. BOT and COL are skipped.
  - BOT phase:
    - Rows 0 up to 63. `lastrowbot` is low only during BOT.
    - The first nonzero `botrowout` sets `botrow` and moves to COL.
  - COL phase:
    - Exactly 24 column requests, indices 23 down to 0, tracked by an internal 5-bit counter. `finalcolumn` is not used.
    - Each nonzero column increments `colcnt`.
    - The first nonzero column sets `colhi`. Each nonzero column overwrites `collo`.
    - After index 0 is sampled → DONE.
  - DONE: pulses `done` for one cycle, then → IDLE. Result outputs hold until the next `alustart` or reset.
- **Scan-start clearing:** at scan start, `empty`, `colcnt`, `toprow`, `botrow`, `colhi`, `collo` and `err` clear to 0.
- **Ready handling:**
  - A ready pulse in any state other than the matching WAIT is ignored.
  - A ready pulse for a different slice type is ignored.
- **`alustart` while busy:** abort the current scan and restart at TOPREQ with cleared results. No `done` is issued for the aborted scan.
- **Reset mid-scan:** immediate return to reset values. No `done`.
- **Counter widths:**
  - The 6-bit row counters terminate on their compare to the end index. They never wrap.
  - `colcnt` saturation is unnecessary because the maximum is 24.

## Timing
- REQ lasts 1 cycle. The request reaches the bitmap register at the next edge, and the ready/slice arrive in the following cycle. Nominal cost is therefore 2 cycles per slice.
- Latency: with N = number of slices consumed, `done` is high 2N+2 cycles after the cycle in which `alustart` was high.
  - Nonempty bitmap: N = (64 − toprow) + (botrow + 1) + 24.
  - Empty bitmap: N = 64, so latency is 130 cycles.
- `busy` goes high the cycle after `alustart`. It goes low in the same cycle that `done` is high.
- A WAIT state holds indefinitely until the ready pulse, unless the timeout is enabled.

## Configuration
- `BMPBOUND_TIMEOUT_EN` defined:
  - Each WAIT state runs a 3-bit counter.
  - If no matching ready pulse arrives within 8 cycles of entering WAIT: `err` = 1, `done` pulses, the other result fields read 0, state → IDLE.
- Not defined: no counter, no `err` port, and WAIT waits forever.

## Test plan
- Single pixel at data bit 24*10+5 (row 10, col 5): `toprow`=10, `botrow`=10, `colhi`=`collo`=5, `colcnt`=1, `empty`=0. `done` 180 cycles after `alustart`.
- All-zero bitmap: `empty`=1, `done` at 130 cycles. No `nextrowbot` or `nextcol` pulses observed.
- All-ones bitmap: `toprow`=63, `botrow`=0, `colhi`=23, `collo`=0, `colcnt`=24. `done` at 2*(1+1+24)+2 = 54 cycles.
- Second `alustart` 40 cycles into a scan, with a new bitmap of bits 0 and 1535 set:
  - No `done` for the first scan.
  - Second result: `toprow`=63, `botrow`=0, `colhi`=23, `collo`=0, `colcnt`=2.
- Reset asserted asynchronously mid-COL:
  - `busy`, `done` and results drop to 0 and `lastrowtop` = `lastrowbot` = 1 immediately.
  - A following `alustart` scans normally.
- With `BMPBOUND_TIMEOUT_EN`, suppress `rowtopready`: `err`=1 with `done` 8 cycles into the first WAIT, then IDLE.

Source files
------------

// File: rtl/bmpbound.sv
// Bounding-box scan of the 24x64 compare bitmap via the bitmap register's request/ready slices.
// Optional handshake timeout (err port, per-WAIT 3-bit counter) is enabled by defining BMPBOUND_TIMEOUT_EN.
`timescale 1ns/1ps
module bmpbound (
  input  logic        clk,
  input  logic        rst,
  input  logic        alustart,
  input  logic [63:0] columnout,
  input  logic [23:0] toprowout,
  input  logic [23:0] botrowout,
  input  logic        colready,
  input  logic        rowtopready,
  input  logic        rowbotready,
  output logic        nextcol,
  output logic        nextrowtop,
  output logic        nextrowbot,
  output logic        lastrowtop,
  output logic        lastrowbot,
  output logic        busy,
  output logic        done,
  output logic        empty,
  output logic [5:0]  toprow,
  output logic [5:0]  botrow,
  output logic [4:0]  colhi,
  output logic [4:0]  collo,
  output logic [4:0]  colcnt
`ifdef BMPBOUND_TIMEOUT_EN
  , output logic      err
`endif
);
  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] TOPREQ  = 3'd1;
  localparam logic [2:0] TOPWAIT = 3'd2;
  localparam logic [2:0] BOTREQ  = 3'd3;
  localparam logic [2:0] BOTWAIT = 3'd4;
  localparam logic [2:0] COLREQ  = 3'd5;
  localparam logic [2:0] COLWAIT = 3'd6;
  localparam logic [2:0] DONE    = 3'd7;

  logic [2:0] state, nstate;
  logic [5:0] rowidx;
  logic [4:0] colidx;
  logic       smp, hit, last, tmo_hit;
`ifdef BMPBOUND_TIMEOUT_EN
  logic [2:0] tmo;
`endif

  always_comb begin
    nstate = state;
    smp    = 1'b0;
    hit    = 1'b0;
    last   = 1'b0;
    case (state)
      TOPREQ:  nstate = TOPWAIT;
      TOPWAIT: if (rowtopready) begin
        smp    = 1'b1;
        hit    = |toprowout;
        last   = (rowidx == 6'd0);
        nstate = hit ? BOTREQ : (last ? DONE : TOPREQ);
      end
      BOTREQ:  nstate = BOTWAIT;
      BOTWAIT: if (rowbotready) begin
        smp    = 1'b1;
        hit    = |botrowout;
        last   = (rowidx == 6'd63);
        nstate = (hit || last) ? COLREQ : BOTREQ;
      end
      COLREQ:  nstate = COLWAIT;
      COLWAIT: if (colready) begin
        smp    = 1'b1;
        hit    = |columnout;
        last   = (colidx == 5'd0);
        nstate = last ? DONE : COLREQ;
      end
      DONE:    nstate = IDLE;
      default: nstate = IDLE;
    endcase
`ifdef BMPBOUND_TIMEOUT_EN
    tmo_hit = (state == TOPWAIT || state == BOTWAIT || state == COLWAIT) && !smp && (tmo == 3'd7);
    if (tmo_hit) nstate = DONE;
`else
    tmo_hit = 1'b0;
`endif
    // a new bitmap always wins, aborting whatever scan is in flight
    if (alustart) nstate = TOPREQ;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      nextcol    <= 1'b0;
      nextrowtop <= 1'b0;
      nextrowbot <= 1'b0;
      lastrowtop <= 1'b1;
      lastrowbot <= 1'b1;
      busy       <= 1'b0;
      done       <= 1'b0;
      empty      <= 1'b0;
      toprow     <= '0;
      botrow     <= '0;
      colhi      <= '0;
      collo      <= '0;
      colcnt     <= '0;
      rowidx     <= '0;
      colidx     <= '0;
`ifdef BMPBOUND_TIMEOUT_EN
      err        <= 1'b0;
      tmo        <= '0;
`endif
    end else begin
      state      <= nstate;
      nextrowtop <= (nstate == TOPREQ);
      nextrowbot <= (nstate == BOTREQ);
      nextcol    <= (nstate == COLREQ);
      lastrowtop <= !(nstate == TOPREQ || nstate == TOPWAIT);
      lastrowbot <= !(nstate == BOTREQ || nstate == BOTWAIT);
      busy       <= (nstate != IDLE);
      done       <= (state == DONE) && !alustart;
`ifdef BMPBOUND_TIMEOUT_EN
      tmo <= (smp || !(state == TOPWAIT || state == BOTWAIT || state == COLWAIT)) ? 3'd0 : tmo + 3'd1;
`endif
      if (alustart) begin
        empty  <= 1'b0;
        toprow <= '0;
        botrow <= '0;
        colhi  <= '0;
        collo  <= '0;
        colcnt <= '0;
        rowidx <= 6'd63;
        colidx <= 5'd23;
`ifdef BMPBOUND_TIMEOUT_EN
        err    <= 1'b0;
`endif
      end else if (tmo_hit) begin
        empty  <= 1'b0;
        toprow <= '0;
        botrow <= '0;
        colhi  <= '0;
        collo  <= '0;
        colcnt <= '0;
`ifdef BMPBOUND_TIMEOUT_EN
        err    <= 1'b1;
`endif
      end else if (smp) begin
        case (state)
          TOPWAIT:
            if (hit) begin
              toprow <= rowidx;
              rowidx <= 6'd0;
            end else if (last) empty <= 1'b1;
            else rowidx <= rowidx - 6'd1;
          BOTWAIT:
            if (hit) botrow <= rowidx;
            else if (!last) rowidx <= rowidx + 6'd1;
          COLWAIT: begin
            if (hit) begin
              colcnt <= colcnt + 5'd1;
              collo  <= colidx;
              // colcnt still zero means this is the first occupied column
              if (colcnt == 5'd0) colhi <= colidx;
            end
            if (!last) colidx <= colidx - 5'd1;
          end
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_bmpbound.sv
// Directed bench for bmpbound: a behavioural bitmap register answers the slice requests.
`timescale 1ns/1ps
module tb_bmpbound;
  logic        clk = 0, rst = 1, alustart = 0;
  logic [63:0] columnout = '0;
  logic [23:0] toprowout = '0, botrowout = '0;
  logic        colready = 0, rowtopready = 0, rowbotready = 0;
  logic        nextcol, nextrowtop, nextrowbot, lastrowtop, lastrowbot, busy, done, empty;
  logic [5:0]  toprow, botrow;
  logic [4:0]  colhi, collo, colcnt;
`ifdef BMPBOUND_TIMEOUT_EN
  logic        err;
`endif

  logic [1535:0] bmp = '0;
  logic spur = 0, sup = 0;
  int ntop = 0, nbot = 0, ncol = 0;
  int nchk = 0, nbad = 0;

  bmpbound dut (
    .clk(clk), .rst(rst), .alustart(alustart),
    .columnout(columnout), .toprowout(toprowout), .botrowout(botrowout),
    .colready(colready), .rowtopready(rowtopready), .rowbotready(rowbotready),
    .nextcol(nextcol), .nextrowtop(nextrowtop), .nextrowbot(nextrowbot),
    .lastrowtop(lastrowtop), .lastrowbot(lastrowbot),
    .busy(busy), .done(done), .empty(empty),
    .toprow(toprow), .botrow(botrow), .colhi(colhi), .collo(collo), .colcnt(colcnt)
`ifdef BMPBOUND_TIMEOUT_EN
    , .err(err)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [23:0] rowslice(input int r);
    return bmp[r*24 +: 24];
  endfunction

  function automatic logic [63:0] colslice(input int c);
    logic [63:0] v;
    for (int r = 0; r < 64; r++) v[63-r] = bmp[r*24+c];
    return v;
  endfunction

  // bitmap register model: a request seen in one cycle is answered with ready+slice in the next
  initial begin
    int tptr, bptr, cptr;
    logic pt, pb, pc;
    tptr = 63; bptr = 0; cptr = 23; pt = 0; pb = 0; pc = 0;
    forever begin
      @(negedge clk);
      rowtopready = 0; rowbotready = 0; colready = 0;
      if (rst || alustart) begin
        tptr = 63; bptr = 0; cptr = 23; pt = 0; pb = 0; pc = 0;
      end else begin
        if (pt && !sup) begin
          toprowout = rowslice(tptr); rowtopready = 1;
          if (tptr > 0) tptr--;
          if (spur) begin colready = 1; columnout = '1; rowbotready = 1; botrowout = '1; end
        end
        if (pb) begin
          botrowout = rowslice(bptr); rowbotready = 1;
          if (bptr < 63) bptr++;
          if (spur) begin colready = 1; columnout = '1; end
        end
        if (pc) begin
          columnout = colslice(cptr); colready = 1;
          if (cptr > 0) cptr--;
          if (spur) begin rowtopready = 1; toprowout = '1; rowbotready = 1; botrowout = '1; end
        end
        pt = nextrowtop; pb = nextrowbot; pc = nextcol;
        ntop += int'(nextrowtop); nbot += int'(nextrowbot); ncol += int'(nextcol);
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    if (obs !== exp) begin
      nbad++;
      $display("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  // launch a scan and wait (bounded) for done; lat = cycles from the alustart cycle
  task automatic run_scan(output int lat);
    @(posedge clk); #1 alustart = 1;
    @(posedge clk); #1 alustart = 0;
    chk("busy_c1", busy, 1);
    lat = 1;
    while (!done && lat < 400) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("done_seen", done, 1);
    chk("busy_at_done", busy, 0);
  endtask

  initial begin
    int lat, t0, b0, c0, dcnt;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_lasttop", lastrowtop, 1);
    chk("rst_lastbot", lastrowbot, 1);
    chk("rst_toprow", toprow, 0);
    chk("rst_nextcol", nextcol, 0);
    @(negedge clk) rst = 0;

    // single pixel row 10, col 5
    bmp = '0; bmp[24*10+5] = 1'b1;
    t0 = ntop; b0 = nbot; c0 = ncol;
    run_scan(lat);
    chk("px_lat", lat, 180);
    chk("px_toprow", toprow, 10);
    chk("px_botrow", botrow, 10);
    chk("px_colhi", colhi, 5);
    chk("px_collo", collo, 5);
    chk("px_colcnt", colcnt, 1);
    chk("px_empty", empty, 0);
    chk("px_ntop", ntop - t0, 54);
    chk("px_nbot", nbot - b0, 11);
    chk("px_ncol", ncol - c0, 24);
    @(posedge clk); #1;
    chk("px_done_1cyc", done, 0);
    chk("px_hold", toprow, 10);

    // same pixel with stray ready pulses of the wrong type / in the wrong state
    spur = 1;
    run_scan(lat);
    spur = 0;
    chk("spur_lat", lat, 180);
    chk("spur_toprow", toprow, 10);
    chk("spur_botrow", botrow, 10);
    chk("spur_colhi", colhi, 5);
    chk("spur_collo", collo, 5);
    chk("spur_colcnt", colcnt, 1);

    // all zero
    bmp = '0;
    t0 = ntop; b0 = nbot; c0 = ncol;
    run_scan(lat);
    chk("zero_lat", lat, 130);
    chk("zero_empty", empty, 1);
    chk("zero_colcnt", colcnt, 0);
    chk("zero_ntop", ntop - t0, 64);
    chk("zero_nbot", nbot - b0, 0);
    chk("zero_ncol", ncol - c0, 0);

    // all ones
    bmp = '1;
    run_scan(lat);
    chk("ones_lat", lat, 54);
    chk("ones_toprow", toprow, 63);
    chk("ones_botrow", botrow, 0);
    chk("ones_colhi", colhi, 23);
    chk("ones_collo", collo, 0);
    chk("ones_colcnt", colcnt, 24);
    chk("ones_empty", empty, 0);

    // restart 40 cycles into a scan
    bmp = '0; bmp[24*10+5] = 1'b1;
    @(posedge clk); #1 alustart = 1;
    @(posedge clk); #1 alustart = 0;
    dcnt = 0;
    for (int i = 1; i < 40; i++) begin
      if (i == 3) begin
        chk("top_lasttop", lastrowtop, 0);
        chk("top_lastbot", lastrowbot, 1);
      end
      dcnt += int'(done);
      if (i < 39) begin @(posedge clk); #1; end
    end
    chk("abort_nodone", dcnt, 0);
    bmp = '0; bmp[0] = 1'b1; bmp[1535] = 1'b1;
    run_scan(lat);
    chk("ab_lat", lat, 54);
    chk("ab_toprow", toprow, 63);
    chk("ab_botrow", botrow, 0);
    chk("ab_colhi", colhi, 23);
    chk("ab_collo", collo, 0);
    chk("ab_colcnt", colcnt, 2);

    // asynchronous reset in the middle of the column phase
    bmp = '1;
    @(posedge clk); #1 alustart = 1;
    @(posedge clk); #1 alustart = 0;
    repeat (20) @(posedge clk);
    #1;
    chk("midcol_busy", busy, 1);
    #2 rst = 1;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_toprow", toprow, 0);
    chk("arst_colhi", colhi, 0);
    chk("arst_colcnt", colcnt, 0);
    chk("arst_lasttop", lastrowtop, 1);
    chk("arst_lastbot", lastrowbot, 1);
    chk("arst_done", done, 0);
    @(negedge clk); @(negedge clk) rst = 0;
    run_scan(lat);
    chk("post_lat", lat, 54);
    chk("post_toprow", toprow, 63);
    chk("post_colcnt", colcnt, 24);

`ifdef BMPBOUND_TIMEOUT_EN
    sup = 1;
    run_scan(lat);
    sup = 0;
    chk("tmo_err", err, 1);
    chk("tmo_toprow", toprow, 0);
    @(posedge clk); #1;
    chk("tmo_idle", busy, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nchk, nbad);
    $finish;
  end
endmodule
